// File: rtl/sa_ram_rd_pkg.sv
// Shared constants and FSM state type for the SA operand RAM read streamer.
package sa_ram_rd_pkg;

    localparam int unsigned SA_RAM_AW        = 6;
    localparam int unsigned SA_RAM_DW        = 1024;
    localparam int unsigned SA_RAM_DEPTH     = 64;
    localparam int unsigned SA_RD_FIFO_DEPTH = 3;
    localparam int unsigned SA_RD_LW         = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sa_rd_state_e;

endpackage

// File: rtl/sa_ram_rd_fifo3.sv
// 3-entry synchronous FIFO of {last, data}; storage is unreset, pointers/count reset.
module sa_ram_rd_fifo3
    import sa_ram_rd_pkg::*;
#(
    parameter int unsigned W = SA_RAM_DW + 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    localparam int unsigned DEPTH = SA_RD_FIFO_DEPTH;

    logic [W-1:0] mem_q [DEPTH];
    logic [1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign full    = (count_q == 2'(DEPTH));
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sa_ram_rd_streamer.sv
// Burst read engine: drives RAM ra/re, captures dout into a 3-deep FIFO, streams valid/ready/last.
// Optional stall cycle counter port enabled by SA_RAM_RD_STREAMER_STALL_CNT_EN.
module sa_ram_rd_streamer
    import sa_ram_rd_pkg::*;
#(
    parameter int unsigned AW = SA_RAM_AW,
    parameter int unsigned DW = SA_RAM_DW,
    parameter int unsigned LW = SA_RD_LW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic [AW-1:0] ra,
    output logic          re,
    input  logic [DW-1:0] dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done,
    output logic          busy
`ifdef SA_RAM_RD_STREAMER_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    sa_rd_state_e  state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          re_q, re_d;
    logic          re_last_q, re_last_d;
    logic          cap_q, cap_last_q;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          cmd_ready_q, cmd_ready_d;

    logic [LW-1:0] len_c;
    logic [2:0]    occ_c;
    logic          space_c;
    logic          fifo_pop;
    logic [1:0]    fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic [DW:0]   fifo_head;

    sa_ram_rd_fifo3 #(.W(DW + 1)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (cap_q),
        .wdata ({cap_last_q, dout}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_pop  = !fifo_empty && out_ready;
    assign len_c     = (cmd_len > LW'(SA_RAM_DEPTH)) ? LW'(SA_RAM_DEPTH) : cmd_len;
    // Slots committed after this edge: buffered + reads in the RAM pipe, minus the beat leaving now.
    assign occ_c     = 3'(fifo_cnt) + 3'(re_q) + 3'(cap_q) - 3'(fifo_pop);
    assign space_c   = fifo_full ? (fifo_pop && !re_q && !cap_q)
                                 : (occ_c < 3'(SA_RD_FIFO_DEPTH));

    // First read issues on the handshake edge so re appears one cycle after it.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        ra_d       = ra_q;
        rem_d      = rem_q;
        re_d       = 1'b0;
        re_last_d  = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (len_c == LW'(0)) begin
                        rem_d   = LW'(0);
                        state_d = DRAIN;
                    end else begin
                        re_d       = 1'b1;
                        ra_d       = cmd_addr;
                        cur_addr_d = cmd_addr + AW'(1);
                        rem_d      = len_c - LW'(1);
                        re_last_d  = (len_c == LW'(1));
                        state_d    = (len_c == LW'(1)) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if ((rem_q != LW'(0)) && space_c) begin
                    re_d       = 1'b1;
                    ra_d       = cur_addr_q;
                    cur_addr_d = cur_addr_q + AW'(1);
                    rem_d      = rem_q - LW'(1);
                    re_last_d  = (rem_q == LW'(1));
                    if (rem_q == LW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!re_q && !cap_q && (fifo_empty || (fifo_cnt == 2'd1 && fifo_pop))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            ra_q        <= '0;
            rem_q       <= '0;
            re_q        <= 1'b0;
            re_last_q   <= 1'b0;
            cap_q       <= 1'b0;
            cap_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            ra_q        <= ra_d;
            rem_q       <= rem_d;
            re_q        <= re_d;
            re_last_q   <= re_last_d;
            cap_q       <= re_q;
            cap_last_q  <= re_last_q;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign re        = re_q;
    assign ra        = ra_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_head[DW-1:0];
    assign out_last  = !fifo_empty && fifo_head[DW];

`ifdef SA_RAM_RD_STREAMER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_q <= 32'd0;
        end else if (cmd_valid && cmd_ready_q) begin
            stall_cnt_q <= 32'd0;
        end else if (!fifo_empty && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sa_ram_rd_streamer.sv
// Directed bench for sa_ram_rd_streamer with a registered-read-address RAM model.
module tb_sa_ram_rd_streamer;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 1024;
    localparam int unsigned LW = 7;

    logic          clk;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] ra;
    logic          re;
    logic [DW-1:0] dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          busy;
`ifdef SA_RAM_RD_STREAMER_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sa_ram_rd_streamer #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ra        (ra),
        .re        (re),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .busy      (busy)
`ifdef SA_RAM_RD_STREAMER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] v;
        for (int k = 0; k < 32; k++)
            v[k*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'(k) * 32'h0100_0193) ^ 32'hC0DE_0000;
        return v;
    endfunction

    // RAM model: address latched on re, data visible the following cycle
    logic [DW-1:0] mem [64];
    logic [AW-1:0] ram_addr_q;
    always @(posedge clk) if (re) ram_addr_q <= ra;
    assign dout = mem[ram_addr_q];

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            stall;
        int            exp_n;
        int            exp_done;
    } vec_t;

    typedef struct {
        int n_re;
        int n_beats;
        int done_lat;
        int data_err;
        int last_err;
        int ra_err;
        int busy_err;
        int hold_err;
        int re_in_stall;
        int first_re;
        int first_valid;
    } res_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v, output res_t r);
        logic [DW-1:0] prev;
        logic          prev_stall;
        r = '{default: 0};
        r.done_lat    = -1;
        r.first_re    = -1;
        r.first_valid = -1;
        prev       = '0;
        prev_stall = 1'b0;
        @(negedge clk);
        chk("cmd_ready_idle", longint'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        out_ready = (v.stall > 0) ? 1'b0 : 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            out_ready = (c < v.stall) ? 1'b0 : 1'b1;
            if (re) begin
                if (r.first_re < 0) r.first_re = c;
                if (ra != AW'(int'(v.addr) + r.n_re)) r.ra_err++;
                r.n_re++;
                if (c >= 4 && c <= v.stall) r.re_in_stall++;
            end
            if (!busy) r.busy_err++;
            if (out_valid) begin
                if (r.first_valid < 0) r.first_valid = c;
                if (prev_stall && out_data != prev) r.hold_err++;
            end
            if (out_valid && out_ready) begin
                if (out_data != pat((int'(v.addr) + r.n_beats) % 64)) r.data_err++;
                if (out_last != (r.n_beats == v.exp_n - 1)) r.last_err++;
                r.n_beats++;
            end
            prev_stall = out_valid && !out_ready;
            prev       = out_data;
            if (done) begin
                r.done_lat = c;
                break;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_re"},        longint'(re), 0);
        chk({tag, "_ra"},        longint'(ra), 0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_out_last"},  longint'(out_last), 0);
        chk({tag, "_out_data0"}, longint'(out_data == '0), 1);
        chk({tag, "_done"},      longint'(done), 0);
        chk({tag, "_busy"},      longint'(busy), 0);
        chk({tag, "_cmd_ready"}, longint'(cmd_ready), 1);
    endtask

    task automatic chk_vec(input vec_t v, input res_t r);
        chk("n_re",        r.n_re, v.exp_n);
        chk("n_beats",     r.n_beats, v.exp_n);
        chk("data_err",    r.data_err, 0);
        chk("last_err",    r.last_err, 0);
        chk("ra_err",      r.ra_err, 0);
        chk("busy_err",    r.busy_err, 0);
        chk("hold_err",    r.hold_err, 0);
        chk("re_in_stall", r.re_in_stall, 0);
        if (r.done_lat < 0)     chk("done_timeout", r.done_lat, v.exp_done);
        else if (v.exp_done > 0) chk("done_lat", r.done_lat, v.exp_done);
        if (v.stall == 0 && v.exp_n > 0) begin
            chk("first_re",    r.first_re, 1);
            chk("first_valid", r.first_valid, 3);
        end
        if (v.exp_n == 0) begin
            chk("zero_no_re",    r.first_re, -1);
            chk("zero_no_valid", r.first_valid, -1);
        end
    endtask

    vec_t vecs [9];
    res_t res;
    int   bad;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = pat(i);
        vecs[0] = '{6'd5,  7'd4,   0, 4,  7};
        vecs[1] = '{6'd62, 7'd4,   0, 4,  7};
        vecs[2] = '{6'd0,  7'd0,   0, 0,  2};
        vecs[3] = '{6'd10, 7'd64,  0, 64, 67};
        vecs[4] = '{6'd33, 7'd100, 0, 64, 67};
        vecs[5] = '{6'd7,  7'd1,   0, 1,  4};
        vecs[6] = '{6'd20, 7'd10,  8, 10, 18};
        vecs[7] = '{6'd60, 7'd64,  5, 64, 0};
        vecs[8] = '{6'd63, 7'd127, 0, 64, 67};

        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk_reset_vals("rst");

        for (int i = 0; i < 9; i++) begin
            run_burst(vecs[i], res);
            chk_vec(vecs[i], res);
        end

        // Reset during beat 3 of an 8-beat burst
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 6'd40;
        cmd_len   = 7'd8;
        out_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        chk("mid_valid_before_rst", longint'(out_valid), 1);
        rstn = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        rstn = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || out_valid || re || busy) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        run_burst('{6'd3, 7'd5, 0, 5, 8}, res);
        chk_vec('{6'd3, 7'd5, 0, 5, 8}, res);

`ifdef SA_RAM_RD_STREAMER_STALL_CNT_EN
        run_burst(vecs[6], res);
        chk_vec(vecs[6], res);
        chk("stall_cnt_5", longint'(stall_cnt), 5);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 6'd9;
        cmd_len   = 7'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("stall_cnt_clr", longint'(stall_cnt), 0);
        bad = 1;
        for (int c = 0; c < 10 && bad != 0; c++) begin
            if (done) bad = 0;
            else @(negedge clk);
        end
        chk("stall_zero_done", bad, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
